// File: rtl/stopwatch_pkg.sv
// Shared widths, packed time type, field limits and FSM encoding for the
// stopwatch timekeeping core.
package stopwatch_pkg;

  localparam int unsigned HR_W   = 5;
  localparam int unsigned MIN_W  = 6;
  localparam int unsigned SEC_W  = 6;
  localparam int unsigned CS_W   = 7;
  localparam int unsigned TIME_W = HR_W + MIN_W + SEC_W + CS_W;

  localparam logic [CS_W-1:0]  CS_MAX  = 7'd99;
  localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
  localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;

  typedef struct packed {
    logic [HR_W-1:0]  hr;
    logic [MIN_W-1:0] min;
    logic [SEC_W-1:0] sec;
    logic [CS_W-1:0]  cs;
  } time_t;

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_RUNNING = 2'd1,
    ST_EXPIRED = 2'd2
  } state_t;

  function automatic time_t unpack_time(input logic [TIME_W-1:0] v);
    return time_t'(v);
  endfunction

  function automatic logic [TIME_W-1:0] pack_time(input time_t t);
    return t;
  endfunction

  // Clamp each field of an externally supplied preset to its legal range.
  function automatic time_t sat_time(input time_t t,
                                     input logic [CS_W-1:0] cs_top,
                                     input logic [HR_W-1:0] hr_top);
    time_t s;
    s.cs  = (t.cs  > cs_top)  ? cs_top  : t.cs;
    s.sec = (t.sec > SEC_MAX) ? SEC_MAX : t.sec;
    s.min = (t.min > MIN_MAX) ? MIN_MAX : t.min;
    s.hr  = (t.hr  > hr_top)  ? hr_top  : t.hr;
    return s;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Time-base prescaler: one registered tick pulse every DIV enabled cycles,
// with the first pulse consumed exactly DIV cycles after a restart.
module tick_gen #(
  parameter int unsigned DIV = 10
) (
  input  logic CLK100MHZ,
  input  logic rst,
  input  logic restart,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] PRE  = CW'(DIV - 2);

  logic [CW-1:0] r_cnt;
  logic          r_tick;

  // The pulse is raised one count early so the consumer sees it on the
  // DIV-th edge despite the register stage.
  always_ff @(posedge CLK100MHZ) begin
    if (rst || restart) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (enable) begin
      r_cnt  <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
      r_tick <= (r_cnt == PRE);
    end else begin
      r_tick <= 1'b0;
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/stopwatch_lap_core.sv
// Up/down hh:mm:ss.cc timekeeping core with preset load, expiry flag and a
// small lap-split buffer read through a registered port.
module stopwatch_lap_core
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned TICK_HZ   = 100,
  parameter int unsigned LAP_DEPTH = 4,
  parameter int unsigned HR_MAX    = 23,
  localparam int unsigned IDX_W    = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1,
  localparam int unsigned CNT_W    = $clog2(LAP_DEPTH + 1)
) (
  input  logic              CLK100MHZ,
  input  logic              rst,
  input  logic              start_stop,
  input  logic              clear,
  input  logic              lap,
  input  logic              mode,
  input  logic              load,
  input  logic [23:0]       load_time,
  input  logic [IDX_W-1:0]  lap_rd_idx,
  output logic              running,
  output logic              expired,
  output logic [6:0]        centiseconds,
  output logic [5:0]        seconds,
  output logic [5:0]        minutes,
  output logic [4:0]        hours,
  output logic [CNT_W-1:0]  lap_count,
  output logic              lap_full,
  output logic [23:0]       lap_rd_data
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam logic [CS_W-1:0] CS_TOP = CS_W'(TICK_HZ - 1);
  localparam logic [HR_W-1:0] HR_TOP = HR_W'(HR_MAX);

  state_t              r_state;
  time_t               r_time;
  logic                r_mode;
  logic                r_running;
  logic                r_expired;
  logic [CNT_W-1:0]    r_lap_count;
  time_t               r_lap_rd;
  time_t               r_lap_mem [LAP_DEPTH];

  logic                w_tick;
  logic                w_zero;
  logic                w_full;
  logic                w_start;
  logic                w_lap_we;
  logic [IDX_W-1:0]    w_wr_idx;
  time_t               w_inc;
  time_t               w_dec;
  time_t               w_load_val;

  function automatic time_t inc_time(input time_t t);
    time_t n;
    n = t;
    if (t.cs != CS_TOP) n.cs = t.cs + 7'd1;
    else begin
      n.cs = '0;
      if (t.sec != SEC_MAX) n.sec = t.sec + 6'd1;
      else begin
        n.sec = '0;
        if (t.min != MIN_MAX) n.min = t.min + 6'd1;
        else begin
          n.min = '0;
          n.hr  = (t.hr == HR_TOP) ? '0 : t.hr + 5'd1;
        end
      end
    end
    return n;
  endfunction

  function automatic time_t dec_time(input time_t t);
    time_t n;
    n = t;
    if (t.cs != '0) n.cs = t.cs - 7'd1;
    else begin
      n.cs = CS_TOP;
      if (t.sec != '0) n.sec = t.sec - 6'd1;
      else begin
        n.sec = SEC_MAX;
        if (t.min != '0) n.min = t.min - 6'd1;
        else begin
          n.min = MIN_MAX;
          n.hr  = (t.hr == '0) ? HR_TOP : t.hr - 5'd1;
        end
      end
    end
    return n;
  endfunction

  always_comb begin
    w_inc      = inc_time(r_time);
    w_dec      = dec_time(r_time);
    w_load_val = sat_time(unpack_time(load_time), CS_TOP, HR_TOP);
  end

  assign w_zero   = (r_time == '0);
  assign w_full   = (r_lap_count == CNT_W'(LAP_DEPTH));
  // A load in the same cycle wins over start; a zero down-count cannot start.
  assign w_start  = start_stop && !clear && !load && (r_state == ST_STOPPED) &&
                    (!mode || !w_zero);
  assign w_lap_we = !rst && !clear && lap && !w_full && (r_state == ST_RUNNING);
  assign w_wr_idx = IDX_W'(r_lap_count);

  tick_gen #(.DIV(DIV)) u_tick_gen (
    .CLK100MHZ (CLK100MHZ),
    .rst       (rst),
    .restart   (clear || w_start),
    .enable    (r_state == ST_RUNNING),
    .tick      (w_tick)
  );

  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      r_state     <= ST_STOPPED;
      r_time      <= '0;
      r_mode      <= 1'b0;
      r_running   <= 1'b0;
      r_expired   <= 1'b0;
      r_lap_count <= '0;
      r_lap_rd    <= '0;
    end else begin
      r_lap_rd <= (32'(lap_rd_idx) < 32'(r_lap_count)) ? r_lap_mem[lap_rd_idx] : '0;
      if (clear) begin
        r_state     <= ST_STOPPED;
        r_time      <= '0;
        r_running   <= 1'b0;
        r_expired   <= 1'b0;
        r_lap_count <= '0;
      end else begin
        if (w_lap_we) r_lap_count <= r_lap_count + CNT_W'(1);
        unique case (r_state)
          ST_STOPPED: begin
            r_mode <= mode;
            if (load) r_time <= w_load_val;
            else if (w_start) begin
              r_state   <= ST_RUNNING;
              r_running <= 1'b1;
            end
          end
          ST_RUNNING: begin
            // Stop first so a tick landing on the same edge still counts and
            // an expiry produced by that tick takes precedence.
            if (start_stop) begin
              r_state   <= ST_STOPPED;
              r_running <= 1'b0;
            end
            if (w_tick) begin
              if (r_mode) begin
                r_time <= w_dec;
                if (w_dec == '0) begin
                  r_state   <= ST_EXPIRED;
                  r_running <= 1'b0;
                  r_expired <= 1'b1;
                end
              end else begin
                r_time <= w_inc;
              end
            end
          end
          ST_EXPIRED: begin
            if (load) begin
              r_time    <= w_load_val;
              r_state   <= ST_STOPPED;
              r_expired <= 1'b0;
            end
          end
          default: r_state <= ST_STOPPED;
        endcase
      end
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (w_lap_we) r_lap_mem[w_wr_idx] <= r_time;
  end

  assign running      = r_running;
  assign expired      = r_expired;
  assign centiseconds = r_time.cs;
  assign seconds      = r_time.sec;
  assign minutes      = r_time.min;
  assign hours        = r_time.hr;
  assign lap_count    = r_lap_count;
  assign lap_full     = w_full;
  assign lap_rd_data  = r_lap_rd;

endmodule

// File: tb/tb_stopwatch_lap_core.sv
// Directed bench for stopwatch_lap_core: two instances (HR_MAX 23 and 1) are
// compared every cycle against a total-centisecond model plus literal checks.
module tb_stopwatch_lap_core;

  localparam int DIV   = 10;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_stop = 1'b0, clear = 1'b0, lap = 1'b0, mode = 1'b0, load = 1'b0;
  logic [23:0] load_time = '0;
  logic [1:0]  idx = '0;

  logic        run_o [2];
  logic        exp_o [2];
  logic        full_o[2];
  logic [6:0]  cs_o  [2];
  logic [5:0]  sec_o [2];
  logic [5:0]  min_o [2];
  logic [4:0]  hr_o  [2];
  logic [2:0]  cnt_o [2];
  logic [23:0] rd_o  [2];

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  int m_total [2];
  int m_state [2];
  int m_cyc   [2];
  int m_mode  [2];
  int m_lapcnt[2];
  int m_rd    [2];
  int m_laps  [2][DEPTH];

  always #5 clk = ~clk;

  stopwatch_lap_core #(.CLK_HZ(1000), .TICK_HZ(100), .LAP_DEPTH(DEPTH), .HR_MAX(23)) u_dut (
    .CLK100MHZ(clk), .rst(rst), .start_stop(start_stop), .clear(clear), .lap(lap),
    .mode(mode), .load(load), .load_time(load_time), .lap_rd_idx(idx),
    .running(run_o[0]), .expired(exp_o[0]), .centiseconds(cs_o[0]), .seconds(sec_o[0]),
    .minutes(min_o[0]), .hours(hr_o[0]), .lap_count(cnt_o[0]), .lap_full(full_o[0]),
    .lap_rd_data(rd_o[0])
  );

  stopwatch_lap_core #(.CLK_HZ(1000), .TICK_HZ(100), .LAP_DEPTH(DEPTH), .HR_MAX(1)) u_dut_h1 (
    .CLK100MHZ(clk), .rst(rst), .start_stop(start_stop), .clear(clear), .lap(lap),
    .mode(mode), .load(load), .load_time(load_time), .lap_rd_idx(idx),
    .running(run_o[1]), .expired(exp_o[1]), .centiseconds(cs_o[1]), .seconds(sec_o[1]),
    .minutes(min_o[1]), .hours(hr_o[1]), .lap_count(cnt_o[1]), .lap_full(full_o[1]),
    .lap_rd_data(rd_o[1])
  );

  function automatic int hrmax(input int u);
    return (u == 0) ? 23 : 1;
  endfunction

  function automatic int pack(input int hr, input int mn, input int sc, input int cs);
    return (hr << 19) | (mn << 13) | (sc << 7) | cs;
  endfunction

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int sat_total(input logic [23:0] lt, input int u);
    logic [23:0] v;
    int hr, mn, sc, cs;
    v  = lt;
    cs = min2(int'(v[6:0]), 99);
    sc = min2(int'(v[12:7]), 59);
    mn = min2(int'(v[18:13]), 59);
    hr = min2(int'(v[23:19]), hrmax(u));
    return ((hr * 60 + mn) * 60 + sc) * 100 + cs;
  endfunction

  function automatic int total_packed(input int t);
    return pack(t / 360000, (t / 6000) % 60, (t / 100) % 60, t % 100);
  endfunction

  // States: 0 stopped, 1 running, 2 expired.
  function automatic void model_step(input int u);
    int  rdn, ns;
    bit  tk;
    if (rst) begin
      m_total[u] = 0; m_state[u] = 0; m_cyc[u] = 0;
      m_mode[u] = 0; m_lapcnt[u] = 0; m_rd[u] = 0;
      return;
    end
    rdn = (int'(idx) < m_lapcnt[u]) ? m_laps[u][idx] : 0;
    if (clear) begin
      m_total[u] = 0; m_lapcnt[u] = 0; m_state[u] = 0;
    end else begin
      case (m_state[u])
        0: begin
          m_mode[u] = int'(mode);
          if (load) m_total[u] = sat_total(load_time, u);
          else if (start_stop && (!mode || m_total[u] != 0)) begin
            m_state[u] = 1;
            m_cyc[u]   = 0;
          end
        end
        1: begin
          m_cyc[u] = m_cyc[u] + 1;
          tk = (m_cyc[u] % DIV == 0);
          if (lap && m_lapcnt[u] < DEPTH) begin
            m_laps[u][m_lapcnt[u]] = total_packed(m_total[u]);
            m_lapcnt[u] = m_lapcnt[u] + 1;
          end
          ns = start_stop ? 0 : 1;
          if (tk) begin
            if (m_mode[u] != 0) begin
              m_total[u] = m_total[u] - 1;
              if (m_total[u] == 0) ns = 2;
            end else begin
              m_total[u] = (m_total[u] + 1) % ((hrmax(u) + 1) * 360000);
            end
          end
          m_state[u] = ns;
        end
        default: begin
          if (load) begin
            m_total[u] = sat_total(load_time, u);
            m_state[u] = 0;
          end
        end
      endcase
    end
    m_rd[u] = rdn;
  endfunction

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) model_step(u);
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int u = 0; u < 2; u++) begin
        chk($sformatf("m%0d.running", u), int'(run_o[u]),  int'(m_state[u] == 1));
        chk($sformatf("m%0d.expired", u), int'(exp_o[u]),  int'(m_state[u] == 2));
        chk($sformatf("m%0d.cs", u),      int'(cs_o[u]),   m_total[u] % 100);
        chk($sformatf("m%0d.sec", u),     int'(sec_o[u]),  (m_total[u] / 100) % 60);
        chk($sformatf("m%0d.min", u),     int'(min_o[u]),  (m_total[u] / 6000) % 60);
        chk($sformatf("m%0d.hr", u),      int'(hr_o[u]),   m_total[u] / 360000);
        chk($sformatf("m%0d.lap_count", u), int'(cnt_o[u]), m_lapcnt[u]);
        chk($sformatf("m%0d.lap_full", u),  int'(full_o[u]), int'(m_lapcnt[u] == DEPTH));
        chk($sformatf("m%0d.lap_rd", u),    int'(rd_o[u]),   m_rd[u]);
      end
    end
  end

  // Called at a negedge: input is high across exactly one rising edge.
  task automatic pulse(input bit ss, input bit clr, input bit lp, input bit ld);
    start_stop = ss; clear = clr; lap = lp; load = ld;
    @(negedge clk);
    start_stop = 1'b0; clear = 1'b0; lap = 1'b0; load = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    wait_cyc(2);
    chk_en = 1'b1;
    chk("reset.running", int'(run_o[0]), 0);
    chk("reset.cs", int'(cs_o[0]), 0);
    chk("reset.lap_count", int'(cnt_o[0]), 0);
    rst = 1'b0;
    wait_cyc(1);

    // Start, 250 cycles, stop on a tick edge.
    pulse(1, 0, 0, 0);
    wait_cyc(249);
    pulse(1, 0, 0, 0);
    chk("run250.cs", int'(cs_o[0]), 25);
    chk("run250.running", int'(run_o[0]), 0);
    wait_cyc(100);
    chk("held.cs", int'(cs_o[0]), 25);
    pulse(0, 1, 0, 0);

    // Up-count full wrap.
    load_time = 24'(pack(23, 59, 59, 98));
    pulse(0, 0, 0, 1);
    chk("load.hr_sat_h1", int'(hr_o[1]), 1);
    pulse(1, 0, 0, 0);
    wait_cyc(20);
    chk("wrap.hr", int'(hr_o[0]), 0);
    chk("wrap.cs", int'(cs_o[0]), 0);
    chk("wrap.running", int'(run_o[0]), 1);
    chk("wrap_h1.hr", int'(hr_o[1]), 0);
    pulse(1, 0, 0, 0);
    pulse(0, 1, 0, 0);
    load_time = 24'(pack(1, 59, 59, 99));
    pulse(0, 0, 0, 1);
    pulse(1, 0, 0, 0);
    wait_cyc(10);
    chk("wrap_h1b.min", int'(min_o[1]), 0);
    chk("wrap_h1b.hr", int'(hr_o[1]), 0);
    chk("wrap_h1b.running", int'(run_o[1]), 1);
    chk("nowrap.hr", int'(hr_o[0]), 2);
    pulse(1, 0, 0, 0);
    pulse(0, 1, 0, 0);

    // Down-count to expiry.
    mode = 1'b1;
    load_time = 24'(pack(0, 0, 1, 2));
    pulse(0, 0, 0, 1);
    pulse(1, 0, 0, 0);
    wait_cyc(1019);
    chk("down1019.cs", int'(cs_o[0]), 1);
    chk("down1019.running", int'(run_o[0]), 1);
    wait_cyc(1);
    chk("expire.cs", int'(cs_o[0]), 0);
    chk("expire.sec", int'(sec_o[0]), 0);
    chk("expire.expired", int'(exp_o[0]), 1);
    chk("expire.running", int'(run_o[0]), 0);
    pulse(1, 0, 0, 0);
    chk("expire.ss_ignored", int'(exp_o[0]), 1);
    pulse(0, 1, 0, 0);
    chk("expire.cleared", int'(exp_o[0]), 0);
    pulse(1, 0, 0, 0);
    chk("down_zero.no_start", int'(run_o[0]), 0);
    mode = 1'b0;
    wait_cyc(1);

    // Lap buffer fill and overflow.
    pulse(1, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      wait_cyc((k == 0) ? 100 : 99);
      pulse(0, 0, 1, 0);
    end
    chk("laps.count", int'(cnt_o[0]), 4);
    chk("laps.full", int'(full_o[0]), 1);
    for (int i = 0; i < 4; i++) begin
      idx = 2'(i);
      wait_cyc(1);
      chk($sformatf("laps.rd%0d", i), int'(rd_o[0]), 10 * (i + 1));
    end
    pulse(0, 1, 0, 0);
    chk("laps.clr_count", int'(cnt_o[0]), 0);
    wait_cyc(1);
    chk("laps.clr_rd", int'(rd_o[0]), 0);

    // Simultaneous clear/start_stop/lap while running.
    pulse(1, 0, 0, 0);
    wait_cyc(30);
    pulse(1, 1, 1, 0);
    chk("prio.cs", int'(cs_o[0]), 0);
    chk("prio.running", int'(run_o[0]), 0);
    chk("prio.lap_count", int'(cnt_o[0]), 0);

    // Lap + stop together.
    pulse(1, 0, 0, 0);
    wait_cyc(55);
    pulse(1, 0, 1, 0);
    chk("lapstop.count", int'(cnt_o[0]), 1);
    chk("lapstop.running", int'(run_o[0]), 0);
    idx = 2'd0;
    wait_cyc(1);
    chk("lapstop.rd", int'(rd_o[0]), 5);
    pulse(0, 1, 0, 0);

    // Reset mid-run, then tick latency after restart.
    pulse(1, 0, 0, 0);
    wait_cyc(3470);
    chk("mid.sec", int'(sec_o[0]), 3);
    chk("mid.cs", int'(cs_o[0]), 47);
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    chk("rst.cs", int'(cs_o[0]), 0);
    chk("rst.sec", int'(sec_o[0]), 0);
    chk("rst.running", int'(run_o[0]), 0);
    pulse(1, 0, 0, 0);
    wait_cyc(9);
    chk("restart9.cs", int'(cs_o[0]), 0);
    wait_cyc(1);
    chk("restart10.cs", int'(cs_o[0]), 1);
    wait_cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_lap_core.md
# stopwatch_lap_core

Parametrised timekeeping core for the stopwatch design. It divides `CLK100MHZ` into a time-base tick and keeps an hh:mm:ss.cc count that runs either up (stopwatch) or down (timer, with preset load and an expiry flag). It also stores up to `LAP_DEPTH` lap splits in a readable buffer. It sits between the switch debounce/edge logic, which supplies single-cycle command pulses, and the seven-segment display driver, which consumes the time fields.

## Interface
Parameters:
- `CLK_HZ`, default 100_000_000: input clock frequency.
- `TICK_HZ`, default 100: count resolution (100 = centiseconds). `DIV = CLK_HZ/TICK_HZ`, must be ≥ 2.
- `LAP_DEPTH`, default 4: number of lap entries (≥ 1).
- `HR_MAX`, default 23: hour field wraps after this value.

Ports:
- `CLK100MHZ`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `start_stop`  in  1  single-cycle pulse; toggles run/stop.
- `clear`  in  1  single-cycle pulse; zeroes count, laps and expiry.
- `lap`  in  1  single-cycle pulse; records the current time as a split.
- `mode`  in  1  0 = count up, 1 = count down. Sampled only while stopped.
- `load`  in  1  single-cycle pulse; presets the count from `load_time`. Accepted only while stopped.
- `load_time`  in  24  {hr[4:0], min[5:0], sec[5:0], cs[6:0]}.
- `lap_rd_idx`  in  clog2(LAP_DEPTH) (min 1)  lap entry to read; 0 = oldest.
- `running`  out  1  counter is advancing.
- `expired`  out  1  countdown reached zero.
- `centiseconds`  out  7.
- `seconds`  out  6.
- `minutes`  out  6.
- `hours`  out  5.
- `lap_count`  out  clog2(LAP_DEPTH+1)  entries stored.
- `lap_full`  out  1  `lap_count == LAP_DEPTH`.
- `lap_rd_data`  out  24  packed time of entry `lap_rd_idx`. Reads 0 if the index is ≥ `lap_count`.

## Operation
- States: STOPPED, RUNNING, EXPIRED. Reset enters STOPPED with all outputs 0.
- STOPPED + `start_stop` → RUNNING.
  - In down mode the transition happens only if the count is non-zero; a zero count ignores the pulse.
- RUNNING + `start_stop` → STOPPED. The count is held.
- RUNNING, down mode, count reaches 00:00:00.00 → EXPIRED. `running` = 0, `expired` = 1.
- EXPIRED + (`clear` | `load`) → STOPPED with `expired` = 0. `start_stop` is ignored in EXPIRED.
- Up count carries cs 99→0, then sec 59→0, then min 59→0, then hr `HR_MAX`→0.
  - Full wrap to 00:00:00.00 keeps running.
  - The cs field wraps at `TICK_HZ`-1.
- Down count borrows symmetrically: cs 0→99 with sec-1, and so on.
- `load` applies per-field saturation: cs>99→99, sec/min>59→59, hr>`HR_MAX`→`HR_MAX`.
- Laps are accepted only in RUNNING. Each lap writes the current packed time at index `lap_count`, then increments `lap_count`.
  - When `lap_full` = 1, further laps are dropped and existing entries are unchanged.
- `clear` zeroes the count, `lap_count` and `expired`, and forces STOPPED from any state. Lap storage contents need not be cleared, since reads gate on `lap_count`.
- Priority within one cycle: `rst` > `clear` > `load` > `lap` > `start_stop`.
  - `lap` together with `start_stop` while RUNNING captures the time of that cycle, then stops.
  - A tick in the same cycle as a stop still advances the count once.

## Timing
- All inputs are sampled on the rising edge of `CLK100MHZ`. State and time fields update on that same edge, so outputs are registered and visible the next cycle.
- The prescaler resets to 0 on `rst`, `clear` and the start transition. The first tick occurs exactly `DIV` cycles after the start edge; subsequent ticks follow every `DIV` cycles. The prescaler is frozen while not RUNNING.
- The count advances one unit on each tick edge.
- `lap_rd_data` is registered with 1-cycle latency from `lap_rd_idx`. A lap written at edge N is readable at edge N+1, with data at N+2.
- Expiry: the tick edge that produces zero also sets `expired`.

## Structure
- `stopwatch_pkg` holds:
  - field widths
  - the packed time type and pack/unpack helpers
  - the limit constants (`CS_MAX`, `SEC_MAX`, `MIN_MAX`)
  - the state encoding
- Sub-module `tick_gen` (parameter `DIV`; inputs `CLK100MHZ`, `rst`, `restart`, `enable`; output `tick`, a registered one-cycle pulse). The top-level `stopwatch_top` will later instantiate this core in place of its inline counters.

## Test plan
Benches use `CLK_HZ`=1000 and `TICK_HZ`=100, so `DIV`=10.
- Start, wait 250 cycles, stop → cs=25, `running`=0; after 100 more cycles, still cs=25.
- Up mode, load 23:59:59.98, start, 20 cycles → 00:00:00.00, `running`=1. Repeat with `HR_MAX`=1 and load 01:59:59.99 → wraps to 0.
- Down mode, load 00:00:01.02, start, 1020 cycles → all fields 0, `expired`=1, `running`=0; `start_stop` is ignored; `clear` → `expired`=0.
- `LAP_DEPTH`=4: start, lap at cs=10,20,30,40,50 → `lap_count`=4, `lap_full`=1, idx0..3 read 10,20,30,40 (packed); `clear` → `lap_count`=0, reads 0.
- Same-cycle `clear`+`start_stop`+`lap` while RUNNING → count 0, STOPPED, `lap_count`=0. Same-cycle `lap`+`start_stop` → lap equals the held time.
- `rst` asserted mid-run at 00:00:03.47 → next cycle all outputs 0, STOPPED; the first tick after restart arrives exactly 10 cycles after the start pulse.
